// File: rtl/store_lane_buffer.sv
// store_lane_buffer: MEM-stage store lane steering, byte enables and a small
// in-order write buffer draining to data memory over a valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   st_valid/st_ready      store request handshake (st_ready = buffer not full)
//   st_addr/st_wdata/st_op store byte address, right-justified data, op (sw/sb/sh)
//   st_misalign            registered 1-cycle pulse for a rejected request
//   dm_valid/dm_ready      head entry handshake toward data memory
//   dm_addr/dm_wdata       head word address and lane-steered data
//   dm_byteen              head byte enables, bit i = byte lane i
//   ld_addr/ld_check       load address probe
//   ld_hazard              a pending entry targets the same word as ld_addr
//   count                  number of occupied entries
module store_lane_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [AW-1:0]              st_addr,
    input  logic [31:0]                st_wdata,
    input  logic [2:0]                 st_op,
    output logic                       st_misalign,
    output logic                       dm_valid,
    input  logic                       dm_ready,
    output logic [AW-1:0]              dm_addr,
    output logic [31:0]                dm_wdata,
    output logic [3:0]                 dm_byteen,
    input  logic [AW-1:0]              ld_addr,
    input  logic                       ld_check,
    output logic                       ld_hazard,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] OP_SW = 3'b000;
    localparam logic [2:0] OP_SB = 3'b001;
    localparam logic [2:0] OP_SH = 3'b010;

    // Entry storage; only the word tag is kept since dm_addr is word aligned.
    logic [AW-3:0]   tag_q  [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [3:0]      be_q   [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mis_q, mis_d;

    logic [3:0]      lane_be;
    logic [31:0]     lane_data;
    logic            lane_bad;
    logic            push;
    logic            pop;
    logic [1:0]      a;

    // Low load-address bits never matter for a word-granular hazard check.
    logic [1:0]      ld_addr_unused;
    assign ld_addr_unused = ld_addr[1:0];

    assign a = st_addr[1:0];

    always_comb begin
        lane_be   = 4'b0000;
        lane_data = 32'h0;
        lane_bad  = 1'b0;
        case (st_op)
            OP_SW: begin
                if (a == 2'b00) begin
                    lane_be   = 4'b1111;
                    lane_data = st_wdata;
                end else begin
                    lane_bad = 1'b1;
                end
            end
            OP_SB: begin
                lane_be   = 4'b0001 << a;
                lane_data = {4{st_wdata[7:0]}};
            end
            OP_SH: begin
                if (!a[0]) begin
                    lane_be   = a[1] ? 4'b1100 : 4'b0011;
                    lane_data = {2{st_wdata[15:0]}};
                end else begin
                    lane_bad = 1'b1;
                end
            end
            default: lane_bad = 1'b1;
        endcase
    end

    // Full blocks pushes even when the head pops in the same cycle.
    assign st_ready = (count_q != FULL);
    assign dm_valid = (count_q != '0);

    assign push = st_valid & st_ready & ~lane_bad;
    assign pop  = dm_valid & dm_ready;

    // The misalign pulse reports every bad request, accepted slot or not.
    assign mis_d = st_valid & lane_bad;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (push) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Push and pop never hit the same slot: push into an empty buffer has no
    // pop, and a full buffer refuses the push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            mis_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            mis_q   <= mis_d;
            if (push) begin
                tag_q[wr_q]  <= st_addr[AW-1:2];
                data_q[wr_q] <= lane_data;
                be_q[wr_q]   <= lane_be;
                vld_q[wr_q]  <= 1'b1;
            end
            if (pop) begin
                vld_q[rd_q] <= 1'b0;
            end
        end
    end

    // Head outputs are zeroed when empty so the idle bus reads as reset.
    assign dm_addr   = dm_valid ? {tag_q[rd_q], 2'b00} : '0;
    assign dm_wdata  = dm_valid ? data_q[rd_q] : '0;
    assign dm_byteen = dm_valid ? be_q[rd_q] : '0;

    // The entry popping this cycle is still valid here, so it still counts.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_check && vld_q[i] && (tag_q[i] == ld_addr[AW-1:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    assign st_misalign = mis_q;
    assign count       = count_q;

endmodule
